// File: rtl/kyber_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
// Shared constants and type definitions for the Kyber NTT sequencing logic.
//   - Polynomial geometry (KYBER_N, KYBER_Q, NTT_LAYERS)
//   - Butterfly mode codes driven on bf_mode
//   - State encoding of the ntt_seq_ctrl FSM
// ---------------------------------------------------------------------------
package kyber_pkg;

  localparam int KYBER_N    = 256;
  localparam int KYBER_Q    = 3329;
  localparam int NTT_LAYERS = 7;

  // Inverse-NTT scaling constant applied by the datapath in BF_SCALE mode
  localparam int KYBER_F    = 1441;

  // One butterfly touches two coefficients, so a layer is N/2 butterflies
  localparam int BF_PER_LAYER = KYBER_N / 2;

  // Layer number reported while the optional scale pass is running
  localparam logic [2:0] LAST_LAYER  = 3'(NTT_LAYERS - 1);
  localparam logic [2:0] SCALE_LAYER = 3'd7;

  typedef enum logic [1:0] {
    BF_CT    = 2'd0,
    BF_GS    = 2'd1,
    BF_SCALE = 2'd2,
    BF_RSVD  = 2'd3
  } bf_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SCALE = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
// Combinational butterfly address / twiddle generator.
// Ports:
//   inverse  in   0 = forward (CT) ordering, 1 = inverse (GS) ordering
//   scale    in   1 = scale pass, pairs (b, b+128), zeta 0
//   layer    in   forward layer / inverse step 0..6
//   b        in   butterfly counter 0..127 within the layer
//   j        out  lower operand coefficient index
//   j_len    out  upper operand coefficient index (j + len)
//   zeta     out  twiddle ROM index
// ---------------------------------------------------------------------------
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic       inverse,
  input  logic       scale,
  input  logic [2:0] layer,
  input  logic [6:0] b,
  output logic [7:0] j,
  output logic [7:0] j_len,
  output logic [6:0] zeta
);

  logic [7:0] len;
  logic [3:0] sh_g;
  logic [3:0] sh_j;
  logic [6:0] g;

  // Butterfly b belongs to group g; groups are 2*len coefficients wide and
  // b's low bits give the offset inside the group.  Forward halves len each
  // layer, inverse doubles it.  (128>>m)-1 is written as 127>>m so the
  // inverse twiddle base fits in the 7-bit index.
  always_comb begin
    len  = inverse ? (8'd2 << layer) : (8'd128 >> layer);
    sh_g = inverse ? ({1'b0, layer} + 4'd1) : (4'd7 - {1'b0, layer});
    sh_j = inverse ? ({1'b0, layer} + 4'd2) : (4'd8 - {1'b0, layer});
    g    = b >> sh_g;
    j    = ({1'b0, g} << sh_j) | ({1'b0, b} & (len - 8'd1));
    j_len = j + len;
    zeta = inverse ? ((7'h7F >> layer) - g) : ((7'd1 << layer) + g);
    if (scale) begin
      j     = {1'b0, b};
      j_len = {1'b1, b};
      zeta  = '0;
    end
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_seq_ctrl
// Sequencer for the Kyber NTT/INTT butterfly datapath.  Walks the 7 layers
// of a 256-coefficient polynomial, one butterfly per cycle, issuing the read
// pair, twiddle index and mode, then the write pair BF_LAT cycles later.
// Optional macro NTT_CTRL_SCALE_EN: inverse transforms append a scale pass
// (bf_mode = BF_SCALE, layer = 7).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, inverse,
//   poly_sel               transform request (sampled only in IDLE)
//   busy, finish           status; finish is a one-cycle pulse
//   rd_en, rd_addr_a/b,
//   zeta_idx, bf_mode      read side of one butterfly
//   wr_en, wr_addr_a/b     write side, read side delayed BF_LAT cycles
//   layer                  current layer 0..6, 7 during the scale pass
// ---------------------------------------------------------------------------
module ntt_seq_ctrl
  import kyber_pkg::*;
#(
  parameter int BF_LAT = 4,
  parameter int POLY_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  input  logic [POLY_W-1:0] poly_sel,
  output logic              busy,
  output logic              finish,
  output logic              rd_en,
  output logic [POLY_W+7:0] rd_addr_a,
  output logic [POLY_W+7:0] rd_addr_b,
  output logic [6:0]        zeta_idx,
  output logic [1:0]        bf_mode,
  output logic              wr_en,
  output logic [POLY_W+7:0] wr_addr_a,
  output logic [POLY_W+7:0] wr_addr_b,
  output logic [2:0]        layer
);

  localparam int AW = POLY_W + 8;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [6:0]        b_q;
  logic [DW-1:0]     drain_q;
  logic [2:0]        layer_q;
  logic              inverse_q;
  logic [POLY_W-1:0] poly_q;

  logic              rd_en_c;
  logic              busy_c;
  logic              finish_c;
  bf_mode_t          mode_c;
  logic              last_bf;
  logic              drain_done;

  logic [7:0]        j;
  logic [7:0]        j_len;
  logic [6:0]        zeta;

  logic [BF_LAT-1:0] dl_en;
  logic [AW-1:0]     dl_a [BF_LAT];
  logic [AW-1:0]     dl_b [BF_LAT];

  assign last_bf    = (b_q == 7'(BF_PER_LAYER - 1));
  assign drain_done = (drain_q == DW'(BF_LAT - 1));

  ntt_addr_gen u_addr_gen (
    .inverse (inverse_q),
    .scale   (state_q == ST_SCALE),
    .layer   (layer_q),
    .b       (b_q),
    .j       (j),
    .j_len   (j_len),
    .zeta    (zeta)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs.  DRAIN waits until the last write of
  // the layer has left the delay line before the next layer may read, which
  // keeps reads of layer N+1 clear of writes from layer N.
  always_comb begin
    state_d  = state_q;
    rd_en_c  = 1'b0;
    busy_c   = 1'b1;
    finish_c = 1'b0;
    mode_c   = BF_CT;
    case (state_q)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en_c = 1'b1;
        mode_c  = inverse_q ? BF_GS : BF_CT;
        if (last_bf) begin
          state_d = ST_DRAIN;
        end
      end
      ST_SCALE: begin
        rd_en_c = 1'b1;
        mode_c  = BF_SCALE;
        if (last_bf) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          if (layer_q == SCALE_LAYER) begin
            state_d = ST_DONE;
          end else if (layer_q == LAST_LAYER) begin
`ifdef NTT_CTRL_SCALE_EN
            state_d = inverse_q ? ST_SCALE : ST_DONE;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        finish_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_c  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transform context and counters.  The request is captured only in IDLE,
  // so start/inverse/poly_sel changes during a transform have no effect.
  // The layer advances on the DRAIN exit, jumping to 7 for the scale pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q       <= '0;
      drain_q   <= '0;
      layer_q   <= '0;
      inverse_q <= 1'b0;
      poly_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            inverse_q <= inverse;
            poly_q    <= poly_sel;
            layer_q   <= '0;
            b_q       <= '0;
            drain_q   <= '0;
          end
        end
        ST_RUN, ST_SCALE: begin
          b_q     <= b_q + 7'd1;
          drain_q <= '0;
        end
        ST_DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (state_d == ST_RUN) begin
            layer_q <= layer_q + 3'd1;
          end else if (state_d == ST_SCALE) begin
            layer_q <= SCALE_LAYER;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write-side delay line: the gated read pair shifted BF_LAT stages, so the
  // write timing is fixed by construction and reset drops pending writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_en <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else begin
      dl_en[0] <= rd_en_c;
      dl_a[0]  <= rd_addr_a;
      dl_b[0]  <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a[i]  <= dl_a[i-1];
        dl_b[i]  <= dl_b[i-1];
      end
    end
  end

  // Read-side outputs are forced to zero outside read cycles
  assign rd_en     = rd_en_c;
  assign rd_addr_a = rd_en_c ? {poly_q, j}     : '0;
  assign rd_addr_b = rd_en_c ? {poly_q, j_len} : '0;
  assign zeta_idx  = rd_en_c ? zeta : '0;
  assign bf_mode   = rd_en_c ? 2'(mode_c) : 2'(BF_CT);
  assign busy      = busy_c;
  assign finish    = finish_c;
  assign layer     = layer_q;
  assign wr_en     = dl_en[BF_LAT-1];
  assign wr_addr_a = dl_a[BF_LAT-1];
  assign wr_addr_b = dl_b[BF_LAT-1];

endmodule
